// File: rtl/cmp_result_debouncer.sv
// cmp_result_debouncer: debounces comparator smaller/equal/greater flags.
// A relation is committed only after HOLD consecutive valid, legal and identical samples.
// Also pulses on each commit, counts commits with saturation, and keeps a sticky illegal flag.
// Ports: clk, reset (sync, active-high), in_valid + flags in, clear (counter/illegal only);
//        stable_rel, change, change_count, illegal out (all registered).
module cmp_result_debouncer #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             smaller,
  input  logic             equal,
  input  logic             greater,
  input  logic             clear,
  output logic [1:0]       stable_rel,
  output logic             change,
  output logic [CNT_W-1:0] change_count,
  output logic             illegal
);

  localparam int unsigned      RUN_W  = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);
  localparam logic [RUN_W-1:0] ONE_R  = RUN_W'(1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_STABLE  = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       cand, cand_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [1:0]       samp;
  logic             legal;
  logic             commit;

  // One-hot flags map onto the 2-bit relation code; anything else is illegal.
  always_comb begin
    samp  = 2'b00;
    legal = 1'b1;
    case ({smaller, equal, greater})
      3'b100:  samp = 2'b01;
      3'b010:  samp = 2'b10;
      3'b001:  samp = 2'b11;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    run_nxt   = run;
    commit    = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        // Drop the run; a relation that was already committed stays committed.
        cand_nxt  = 2'b00;
        run_nxt   = '0;
        state_nxt = (state == ST_UNKNOWN) ? ST_UNKNOWN : ST_STABLE;
      end else begin
        if ((state == ST_CONFIRM) && (samp == stable_rel)) begin
          // Back to the committed relation: abandon the pending candidate.
          cand_nxt = samp;
          run_nxt  = ONE_R;
        end else if (samp == cand) begin
          run_nxt = (run == HOLD_R) ? run : run + ONE_R;
        end else begin
          cand_nxt = samp;
          run_nxt  = ONE_R;
        end
        // Run saturates at HOLD, so an already-committed cand never re-commits.
        commit = (run_nxt == HOLD_R) && (cand_nxt != stable_rel);
        case (state)
          ST_UNKNOWN: if (commit) state_nxt = ST_STABLE;
          ST_STABLE: begin
            if (commit)                  state_nxt = ST_STABLE;
            else if (samp != stable_rel) state_nxt = ST_CONFIRM;
          end
          ST_CONFIRM: begin
            if (commit || (samp == stable_rel)) state_nxt = ST_STABLE;
          end
          default: state_nxt = ST_UNKNOWN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_UNKNOWN;
      cand         <= 2'b00;
      run          <= '0;
      stable_rel   <= 2'b00;
      change       <= 1'b0;
      change_count <= '0;
      illegal      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cand   <= cand_nxt;
      run    <= run_nxt;
      change <= commit;
      if (commit) stable_rel <= cand_nxt;
      // clear wins over a same-edge increment or illegal set.
      if (clear)                        change_count <= '0;
      else if (commit && !(&change_count)) change_count <= change_count + ONE_C;
      if (clear)                        illegal <= 1'b0;
      else if (in_valid && !legal)      illegal <= 1'b1;
    end
  end

endmodule

// File: doc/cmp_result_debouncer.md
# cmp_result_debouncer

Debounce and event-tracking stage directly downstream of `comparator_nbit`. It samples the `smaller`/`equal`/`greater` flags with a qualifying valid strobe. It publishes a relation only after it has held for `HOLD` consecutive valid samples. It also pulses on every committed change, keeps a saturating change counter, and flags non-one-hot comparator outputs.

## Interface
- `HOLD`, default 4: consecutive valid, legal, identical samples required to commit a relation; legal range 1..255.
- `CNT_W`, default 8: width of `change_count`.

Ports:
- `clk`, input, 1: rising-edge clock; the only clock in the block.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: comparator flags are sampled on this edge.
- `smaller`, input, 1: comparator output, a < b.
- `equal`, input, 1: comparator output, a == b.
- `greater`, input, 1: comparator output, a > b.
- `clear`, input, 1: synchronous clear of `change_count` and `illegal` only.
- `stable_rel`, output, 2: committed relation; 00 unknown, 01 smaller, 10 equal, 11 greater.
- `change`, output, 1: one-cycle pulse on the edge where `stable_rel` takes a new value.
- `change_count`, output, CNT_W: number of commits, saturating at all-ones.
- `illegal`, output, 1: sticky; set by any valid sample whose flags are not one-hot.

## Operation
- Sample encoding: smaller→01, equal→10, greater→11. All other flag combinations (none set, or more than one set) are illegal.
- Internal registers:
  - `cand` (2b): candidate relation.
  - `run` (0..HOLD): current run length.
  - FSM with states UNKNOWN, STABLE, CONFIRM.
- `in_valid=0`: no state changes. `run`, `cand` and the FSM state are preserved, so gaps do not break a run.
- Valid legal sample equal to `cand`: `run` increments, saturating at HOLD.
- Valid legal sample different from `cand`: `cand` takes the sample and `run` becomes 1.
- Valid illegal sample:
  - `illegal` is set to 1.
  - `cand` becomes 00 and `run` becomes 0.
  - The FSM returns to UNKNOWN only if it was in UNKNOWN. Otherwise it goes to STABLE.
  - `stable_rel` is unchanged.
- Commit: when the updated `run` equals HOLD and `cand != stable_rel`:
  - `stable_rel` takes `cand`.
  - `change` is set to 1.
  - `change_count` increments unless it is all-ones.
- FSM transitions:
  - UNKNOWN → STABLE on the first commit.
  - STABLE → CONFIRM on a valid legal sample that differs from `stable_rel`.
  - CONFIRM → STABLE on a commit.
  - CONFIRM → STABLE on a valid legal sample equal to `stable_rel`. This abandons the candidate: `cand` takes the sample and `run` becomes 1.
- `HOLD=1`: every valid legal sample that differs from `stable_rel` commits on its own edge.
- `clear`:
  - Sets `change_count` to 0 and `illegal` to 0 on that edge.
  - Takes priority over a same-edge increment or illegal set.
  - Does not affect `stable_rel`, `change`, `cand`, `run` or the FSM.

## Timing
- All outputs are registered with no combinational input-to-output path.
- Commit latency: if the first of HOLD qualifying samples is taken at edge k, then `stable_rel` and `change` update at edge k+HOLD-1 when there are no valid gaps. Each gap cycle adds one cycle.
- `change` is high for exactly one cycle per commit. Back-to-back commits are possible only with HOLD=1.
- Reset values:
  - `stable_rel`=00, `change`=0, `change_count`=0, `illegal`=0.
  - `cand`=00, `run`=0, FSM=UNKNOWN.
- Reset dominates `clear` and sampling. Reset in the middle of a run discards the partial run.

## Test plan
- Settle reset with HOLD=4, then apply a=5, b=99 (smaller=1) with `in_valid=1` for 4 cycles. Required:
  - `stable_rel`=01 after the 4th edge.
  - `change` high for 1 cycle.
  - `change_count`=1.
- From a stable 01, apply greater for 3 valid cycles, then equal for 4 cycles. Required:
  - No commit to 11.
  - Commit to 10 after the 4th equal sample.
  - `change_count`=2.
- Apply smaller with valid for 1 cycle, `in_valid=0` for 2 cycles, then smaller with valid for 3 cycles. Required: commit lands on the 6th cycle, and `run` survives the gap.
- Apply smaller=1 and greater=1 with `in_valid=1`. Required:
  - `illegal`=1 and stays sticky.
  - `stable_rel` unchanged and the run is restarted.
  - Then pulse `clear`: `illegal`=0 and `change_count`=0, with `stable_rel` retained.
- With CNT_W=2 and HOLD=1, alternate relations for 6 valid cycles. Required: `change_count` sticks at 3 while `change` still pulses each cycle.
- Assert `reset` after 2 of 4 samples of a new relation. Required:
  - All outputs return to their reset values.
  - A new relation needs a full 4 samples to commit.
